cpu_core: RTL and testbench

Multi-cycle 32-bit RISC processor core with one Wishbone-style master port shared by instruction fetch and data load/store. Instructions return on INSTR_I, load data on DAT_I; both are qualified by AKN_I. Top-level compute block of the design, driven by the system control block (clock/reset) and a memory/peripheral slave.

---
 rtl/cpu_core.sv | 152 +++++++++++++++
 tb/tb_cpu_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Multi-cycle 32-bit RISC core with one Wishbone-style master port.
// Instruction fetch and load/store share the port. The core sequences IDLE -> FETCH -> EXEC [-> MEM].
module cpu_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          HALT_ON_F = 1'b1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        AKN_I,
    input  logic [31:0] INSTR_I,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic [31:0] DAT_O,
    output logic        WE_O,
    output logic [31:0] ADR_O
);

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt} state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpXor  = 4'h5;
    localparam logic [3:0] OpSll  = 4'h6;
    localparam logic [3:0] OpSrl  = 4'h7;
    localparam logic [3:0] OpAddi = 4'h8;
    localparam logic [3:0] OpLui  = 4'h9;
    localparam logic [3:0] OpLw   = 4'hA;
    localparam logic [3:0] OpSw   = 4'hB;
    localparam logic [3:0] OpBeq  = 4'hC;
    localparam logic [3:0] OpBne  = 4'hD;
    localparam logic [3:0] OpJal  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q;
    logic [31:0] regs_q [16];

    logic        wb_en;
    logic [31:0] wb_data;

    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] simm, rs1_val, rs2_val, rd_val, ea, pc_plus4;

    assign op       = ir_q[31:28];
    assign rd       = ir_q[27:24];
    assign rs1      = ir_q[23:20];
    assign rs2      = ir_q[19:16];
    assign simm     = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs1_val  = (rs1 == 4'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val  = (rs2 == 4'd0) ? 32'd0 : regs_q[rs2];
    assign rd_val   = (rd == 4'd0) ? 32'd0 : regs_q[rd];
    assign ea       = rs1_val + simm;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wb_en   = 1'b0;
        wb_data = 32'd0;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (AKN_I) state_d = StExec;
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_plus4;
                case (op)
                    OpNop: ;
                    OpAdd:  begin wb_en = 1'b1; wb_data = rs1_val + rs2_val; end
                    OpSub:  begin wb_en = 1'b1; wb_data = rs1_val - rs2_val; end
                    OpAnd:  begin wb_en = 1'b1; wb_data = rs1_val & rs2_val; end
                    OpOr:   begin wb_en = 1'b1; wb_data = rs1_val | rs2_val; end
                    OpXor:  begin wb_en = 1'b1; wb_data = rs1_val ^ rs2_val; end
                    OpSll:  begin wb_en = 1'b1; wb_data = rs1_val << rs2_val[4:0]; end
                    OpSrl:  begin wb_en = 1'b1; wb_data = rs1_val >> rs2_val[4:0]; end
                    OpAddi: begin wb_en = 1'b1; wb_data = ea; end
                    OpLui:  begin wb_en = 1'b1; wb_data = {ir_q[15:0], 16'h0000}; end
                    OpLw, OpSw: begin
                        // PC advances only once the memory cycle completes.
                        state_d = StMem;
                        pc_d    = pc_q;
                    end
                    OpBeq: if (rd_val == rs1_val) pc_d = pc_plus4 + {simm[29:0], 2'b00};
                    OpBne: if (rd_val != rs1_val) pc_d = pc_plus4 + {simm[29:0], 2'b00};
                    OpJal: begin
                        wb_en   = 1'b1;
                        wb_data = pc_plus4;
                        pc_d    = {ea[31:2], 2'b00};
                    end
                    OpHalt: begin
                        if (HALT_ON_F) begin
                            state_d = StHalt;
                            pc_d    = pc_q;
                        end
                    end
                    default: ;
                endcase
            end
            StMem: begin
                if (AKN_I) begin
                    state_d = StFetch;
                    pc_d    = pc_plus4;
                    if (op == OpLw) begin
                        wb_en   = 1'b1;
                        wb_data = DAT_I;
                    end
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        STB_O = 1'b0;
        WE_O  = 1'b0;
        ADR_O = 32'd0;
        DAT_O = 32'd0;
        case (state_q)
            StFetch: begin
                STB_O = 1'b1;
                ADR_O = {pc_q[31:2], 2'b00};
            end
            StMem: begin
                STB_O = 1'b1;
                ADR_O = {ea[31:2], 2'b00};
                WE_O  = (op == OpSw);
                DAT_O = (op == OpSw) ? rd_val : 32'd0;
            end
            StExec, StHalt: ADR_O = {pc_q[31:2], 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == StFetch && AKN_I) ir_q <= INSTR_I;
            if (wb_en && rd != 4'd0) regs_q[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Randomized self-checking bench for cpu_core: the bench acts as the bus slave and
// runs an instruction-level model that predicts every bus cycle the core should issue.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n, akn;
    logic [31:0] instr, dat_i;
    logic        stb, we;
    logic [31:0] dat_o, adr;

    always #5 clk = ~clk;

    cpu_core #(.RESET_PC(32'h0000_0000), .HALT_ON_F(1'b1)) dut (
        .CLK_I  (clk),
        .RST_I  (rst_n),
        .AKN_I  (akn),
        .INSTR_I(instr),
        .DAT_I  (dat_i),
        .STB_O  (stb),
        .DAT_O  (dat_o),
        .WE_O   (we),
        .ADR_O  (adr)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mregs [16];
    logic [31:0] mpc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [3:0] i);
        return (i == 4'd0) ? 32'd0 : mregs[i];
    endfunction

    task automatic wr(input logic [3:0] i, input logic [31:0] v);
        if (i != 4'd0) mregs[i] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
        mpc = 32'd0;
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input int imm);
        return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
    endfunction

    // Called at a falling edge; waits for a request, checks it, inserts wait states, acks.
    task automatic bus_cycle(input logic [31:0] rdata, input int waits_in,
                             input logic [31:0] exp_adr, input logic exp_we,
                             input logic [31:0] exp_dat, input bit chk_dat);
        int n = 0;
        int waits = waits_in;
        while (stb !== 1'b1 && n < 20) begin
            akn = 1'($urandom);
            @(negedge clk);
            n++;
        end
        akn = 1'b0;
        check("bus_req", 32'(stb), 32'd1);
        if (stb !== 1'b1) return;
        if (waits < 0) waits = $urandom_range(0, 2);
        check("bus_adr", adr, exp_adr);
        check("bus_we", 32'(we), 32'(exp_we));
        if (chk_dat) check("bus_dat", dat_o, exp_dat);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("hold_stb", 32'(stb), 32'd1);
            check("hold_adr", adr, exp_adr);
            if (chk_dat) check("hold_dat", dat_o, exp_dat);
        end
        akn   = 1'b1;
        instr = rdata;
        dat_i = rdata;
        @(negedge clk);
        akn = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic [31:0] ld, input int waits);
        logic [3:0]  op, rd, rs1, rs2;
        logic [31:0] simm, a, b, c, npc, ea;
        op   = ir[31:28];
        rd   = ir[27:24];
        rs1  = ir[23:20];
        rs2  = ir[19:16];
        simm = {{16{ir[15]}}, ir[15:0]};
        a    = rr(rs1);
        b    = rr(rs2);
        c    = rr(rd);
        npc  = mpc + 32'd4;
        ea   = (a + simm) & 32'hFFFF_FFFC;
        bus_cycle(ir, waits, mpc, 1'b0, 32'd0, 1'b0);
        case (op)
            4'h1: wr(rd, a + b);
            4'h2: wr(rd, a - b);
            4'h3: wr(rd, a & b);
            4'h4: wr(rd, a | b);
            4'h5: wr(rd, a ^ b);
            4'h6: wr(rd, a << b[4:0]);
            4'h7: wr(rd, a >> b[4:0]);
            4'h8: wr(rd, a + simm);
            4'h9: wr(rd, {ir[15:0], 16'h0000});
            4'hA: begin
                bus_cycle(ld, waits, ea, 1'b0, 32'd0, 1'b0);
                wr(rd, ld);
            end
            4'hB: bus_cycle(32'd0, waits, ea, 1'b1, c, 1'b1);
            4'hC: if (c == a) npc = mpc + 32'd4 + (simm << 2);
            4'hD: if (c != a) npc = mpc + 32'd4 + (simm << 2);
            4'hE: begin
                wr(rd, mpc + 32'd4);
                npc = ea;
            end
            default: ;
        endcase
        mpc = npc;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        akn   = 1'b0;
        instr = 32'd0;
        dat_i = 32'd0;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            check("rst_stb", 32'(stb), 32'd0);
            check("rst_adr", adr, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("first_fetch_stb", 32'(stb), 32'd1);
        check("first_fetch_adr", adr, 32'd0);

        // Directed program: ALU, wait states, branches, jump, r0.
        run_instr(enc(0, 0, 0, 0, 0), 32'd0, 0);
        run_instr(enc(8, 1, 0, 0, 5), 32'd0, 0);
        run_instr(enc(8, 2, 0, 0, -3), 32'd0, 0);
        run_instr(enc(1, 3, 1, 2, 0), 32'd0, 0);
        run_instr(enc(11, 3, 0, 0, 'h100), 32'd0, 0);
        run_instr(enc(2, 4, 1, 2, 0), 32'd0, 0);
        run_instr(enc(6, 5, 1, 1, 0), 32'd0, 0);
        run_instr(enc(11, 5, 0, 0, 'h104), 32'd0, 0);
        run_instr(enc(11, 4, 0, 0, 'h108), 32'd0, 0);
        run_instr(enc(10, 6, 0, 0, 'h200), 32'hDEAD_BEEF, 4);
        run_instr(enc(11, 6, 0, 0, 'h10C), 32'd0, 0);
        run_instr(enc(12, 0, 0, 0, 2), 32'd0, 0);
        run_instr(enc(13, 0, 0, 0, 5), 32'd0, 0);
        run_instr(enc(14, 5, 0, 0, 'h40), 32'd0, 0);
        run_instr(enc(11, 5, 0, 0, 0), 32'd0, 0);
        run_instr(enc(14, 7, 7, 0, 'h80), 32'd0, 1);
        run_instr(enc(8, 0, 0, 0, 7), 32'd0, 0);
        run_instr(enc(11, 0, 0, 0, 4), 32'd0, 0);

        // Random instruction stream (no halt), random wait states and data.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] ir;
            ir = $urandom;
            ir[31:28] = 4'($urandom_range(0, 14));
            run_instr(ir, $urandom, -1);
        end
        for (int r = 1; r < 16; r++) run_instr(enc(11, r, 0, 0, r * 4), 32'd0, -1);

        // Halt: bus stays idle despite acknowledges.
        bus_cycle(enc(15, 0, 0, 0, 0), 0, mpc, 1'b0, 32'd0, 1'b0);
        repeat (20) begin
            akn = 1'($urandom);
            @(negedge clk);
            check("halt_stb", 32'(stb), 32'd0);
        end
        akn = 1'b0;

        // Reset in the middle of a store.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_instr(enc(8, 3, 0, 0, 'h55), 32'd0, 0);
        bus_cycle(enc(11, 3, 0, 0, 'h300), 0, mpc, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check("mid_mem_stb", 32'(stb), 32'd1);
        check("mid_mem_we", 32'(we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_stb", 32'(stb), 32'd0);
        check("async_rst_adr", adr, 32'd0);
        check("async_rst_dat", dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_instr(enc(11, 3, 0, 0, 'h300), 32'd0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
